// File: rtl/parking_zone_ctrl.sv
// parking_zone_ctrl: multi-zone parking occupancy counter with tick-sampled sensors
// and a timed entry gate per zone.
module parking_zone_ctrl #(
  parameter int ZONES      = 4,
  parameter int CAP_W      = 8,
  parameter int CAPACITY   = 15,
  parameter int DIV_VAL    = 200000,
  parameter int GATE_TICKS = 4,
  parameter int TOT_W      = CAP_W + $clog2(ZONES)
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic [ZONES-1:0]       car_enter,
  input  logic [ZONES-1:0]       car_exit,
  output logic [ZONES*CAP_W-1:0] spots,
  output logic [ZONES-1:0]       zone_full,
  output logic [ZONES-1:0]       zone_empty,
  output logic [TOT_W-1:0]       total_free,
  output logic [ZONES-1:0]       gate_open,
  output logic [ZONES-1:0]       reject,
  output logic [ZONES-1:0]       underflow,
  output logic                   tick_out
);
  localparam int DIV_W = DIV_VAL > 1 ? $clog2(DIV_VAL) : 1;
  localparam int TMR_W = $clog2(GATE_TICKS + 1);
  localparam logic [CAP_W-1:0] CAP = CAP_W'(CAPACITY);
  typedef enum logic {CLOSED, OPEN} gate_t;
  logic [DIV_W-1:0] r_div;
  logic             w_tick;
  logic [ZONES-1:0] r_en1, r_en2, r_ex1, r_ex2, r_pen, r_pex;
  logic [ZONES-1:0] w_ev_en, w_ev_ex, w_acc, w_rej, w_unf;
  logic [ZONES-1:0] r_full, r_empty, r_rej, r_unf;
  logic [CAP_W-1:0] r_occ     [ZONES];
  logic [CAP_W-1:0] w_occ_nxt [ZONES];
  logic [TOT_W-1:0] w_tot_nxt, r_tot;
  gate_t            r_st      [ZONES];
  gate_t            w_st_nxt  [ZONES];
  logic [TMR_W-1:0] r_tmr     [ZONES];
  logic [TMR_W-1:0] w_tmr_nxt [ZONES];

  assign w_tick   = r_div == DIV_W'(DIV_VAL - 1);
  assign tick_out = w_tick;
  assign w_ev_en  = {ZONES{w_tick}} & r_en2 & ~r_pen;
  assign w_ev_ex  = {ZONES{w_tick}} & r_ex2 & ~r_pex;

  // Previous-sample registers reset high so a sensor held through reset is not an event
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_div <= '0;
      {r_en1, r_en2, r_ex1, r_ex2} <= '0;
      r_pen <= '1;
      r_pex <= '1;
    end else begin
      r_div <= w_tick ? '0 : r_div + DIV_W'(1);
      r_en1 <= car_enter;
      r_en2 <= r_en1;
      r_ex1 <= car_exit;
      r_ex2 <= r_ex1;
      if (w_tick) begin
        r_pen <= r_en2;
        r_pex <= r_ex2;
      end
    end
  end

  for (genvar z = 0; z < ZONES; z++) begin : g_zone
    logic w_is_full, w_is_empty;
    assign w_is_full    = r_occ[z] == CAP;
    assign w_is_empty   = r_occ[z] == '0;
    assign w_acc[z]     = w_ev_en[z] & (w_ev_ex[z] | ~w_is_full);
    assign w_rej[z]     = w_ev_en[z] & ~w_ev_ex[z] & w_is_full;
    assign w_unf[z]     = w_ev_ex[z] & ~w_ev_en[z] & w_is_empty;
    assign w_occ_nxt[z] = (w_acc[z] & ~w_ev_ex[z]) ? r_occ[z] + CAP_W'(1) :
                          (w_ev_ex[z] & ~w_ev_en[z] & ~w_is_empty) ? r_occ[z] - CAP_W'(1) : r_occ[z];
    assign spots[z*CAP_W +: CAP_W] = CAP - r_occ[z];
  end

  always_comb begin
    w_tot_nxt = '0;
    for (int i = 0; i < ZONES; i++) w_tot_nxt = w_tot_nxt + TOT_W'(CAP - w_occ_nxt[i]);
  end

  // Flags and total are registered from next-state occupancy to line up with spots
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_full  <= '0;
      r_empty <= '1;
      r_tot   <= TOT_W'(ZONES * CAPACITY);
      r_rej   <= '0;
      r_unf   <= '0;
      for (int i = 0; i < ZONES; i++) r_occ[i] <= '0;
    end else begin
      r_tot <= w_tot_nxt;
      r_rej <= w_rej;
      r_unf <= r_unf | w_unf;
      for (int i = 0; i < ZONES; i++) begin
        r_occ[i]   <= w_occ_nxt[i];
        r_full[i]  <= w_occ_nxt[i] == CAP;
        r_empty[i] <= w_occ_nxt[i] == '0;
      end
    end
  end

  assign zone_full  = r_full;
  assign zone_empty = r_empty;
  assign total_free = r_tot;
  assign reject     = r_rej;
  assign underflow  = r_unf;

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      for (int i = 0; i < ZONES; i++) begin
        r_st[i]  <= CLOSED;
        r_tmr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ZONES; i++) begin
        r_st[i]  <= w_st_nxt[i];
        r_tmr[i] <= w_tmr_nxt[i];
      end
    end
  end

  // An accepted entry wins over the closing tick, so it always reloads the timer
  always_comb begin
    for (int i = 0; i < ZONES; i++) begin
      w_st_nxt[i]  = r_st[i];
      w_tmr_nxt[i] = r_tmr[i];
      if (w_acc[i]) begin
        w_st_nxt[i]  = OPEN;
        w_tmr_nxt[i] = TMR_W'(GATE_TICKS);
      end else if (r_st[i] == OPEN && w_tick) begin
        w_tmr_nxt[i] = r_tmr[i] - TMR_W'(1);
        w_st_nxt[i]  = r_tmr[i] == TMR_W'(1) ? CLOSED : OPEN;
      end
    end
  end

  always_comb begin
    gate_open = '0;
    for (int i = 0; i < ZONES; i++) gate_open[i] = r_st[i] == OPEN;
  end
endmodule

// File: tb/tb_parking_zone_ctrl.sv
// tb_parking_zone_ctrl: directed bench for parking_zone_ctrl with DIV_VAL=4, CAPACITY=3,
// ZONES=4, GATE_TICKS=2; inputs change and outputs are sampled on the falling edge.
module tb_parking_zone_ctrl;
  localparam int TW = 8 + 2;
  logic          clk_in = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    car_enter = '0;
  logic [3:0]    car_exit = '0;
  logic [31:0]   spots;
  logic [3:0]    zone_full, zone_empty, gate_open, reject, underflow;
  logic [TW-1:0] total_free;
  logic          tick_out;
  int            checks = 0;
  int            errors = 0;

  parking_zone_ctrl #(.ZONES(4), .CAP_W(8), .CAPACITY(3), .DIV_VAL(4), .GATE_TICKS(2)) dut (
    .clk_in(clk_in), .reset(reset), .car_enter(car_enter), .car_exit(car_exit),
    .spots(spots), .zone_full(zone_full), .zone_empty(zone_empty), .total_free(total_free),
    .gate_open(gate_open), .reject(reject), .underflow(underflow), .tick_out(tick_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] sp(input int z);
    return spots[z*8 +: 8];
  endfunction

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!tick_out && n < 20);
    if (!tick_out) begin
      checks++; errors++;
      $display("FAIL tick_timeout: no tick within %0d cycles", n);
    end
  endtask

  task automatic do_event(input logic [3:0] en, input logic [3:0] ex);
    wait_tick();
    car_enter = en;
    car_exit  = ex;
    wait_tick();
    @(negedge clk_in);
  endtask

  task automatic release_all();
    car_enter = '0;
    car_exit  = '0;
    wait_tick();
    wait_tick();
  endtask

  task automatic check_reset_values(input string tag);
    checks++; if (spots !== {4{8'd3}}) begin errors++; $display("FAIL %s_spots: got %h exp 03030303", tag, spots); end
    checks++; if (total_free !== TW'(12)) begin errors++; $display("FAIL %s_total: got %0d exp 12", tag, total_free); end
    checks++; if (zone_empty !== 4'hF) begin errors++; $display("FAIL %s_empty: got %b exp 1111", tag, zone_empty); end
    checks++; if (zone_full !== 4'h0) begin errors++; $display("FAIL %s_full: got %b exp 0000", tag, zone_full); end
    checks++; if ({gate_open, reject, underflow, tick_out} !== 13'd0) begin
      errors++; $display("FAIL %s_misc: gate %b rej %b unf %b tick %b exp all 0", tag, gate_open, reject, underflow, tick_out);
    end
  endtask

  task automatic test_reset();
    int n = 0;
    reset = 1'b0;
    car_enter = 4'b0001;
    repeat (3) @(negedge clk_in);
    check_reset_values("rst");
    reset = 1'b1;
    do begin
      @(negedge clk_in);
      n++;
    end while (!tick_out && n < 10);
    checks++; if (n !== 3) begin errors++; $display("FAIL first_tick: got at cycle %0d exp 3", n); end
    wait_tick();
    wait_tick();
    checks++; if (sp(0) !== 8'd3) begin errors++; $display("FAIL held_enter: spots0 got %0d exp 3", sp(0)); end
    release_all();
  endtask

  task automatic test_fill_reject();
    logic [7:0] exp_sp [3] = '{8'd2, 8'd1, 8'd0};
    for (int k = 0; k < 3; k++) begin
      do_event(4'b0010, 4'b0000);
      checks++; if (sp(1) !== exp_sp[k]) begin errors++; $display("FAIL fill_spots%0d: got %0d exp %0d", k, sp(1), exp_sp[k]); end
      checks++; if (gate_open[1] !== 1'b1) begin errors++; $display("FAIL fill_gate%0d: got %b exp 1", k, gate_open[1]); end
      release_all();
    end
    checks++; if (zone_full[1] !== 1'b1) begin errors++; $display("FAIL full1: got %b exp 1", zone_full[1]); end
    do_event(4'b0010, 4'b0000);
    checks++; if (reject !== 4'b0010) begin errors++; $display("FAIL reject_pulse: got %b exp 0010", reject); end
    checks++; if (sp(1) !== 8'd0) begin errors++; $display("FAIL reject_spots: got %0d exp 0", sp(1)); end
    checks++; if (gate_open[1] !== 1'b0) begin errors++; $display("FAIL reject_gate: got %b exp 0", gate_open[1]); end
    checks++; if (total_free !== TW'(9)) begin errors++; $display("FAIL reject_total: got %0d exp 9", total_free); end
    @(negedge clk_in);
    checks++; if (reject !== 4'b0000) begin errors++; $display("FAIL reject_width: got %b exp 0000", reject); end
    release_all();
  endtask

  task automatic test_simultaneous();
    repeat (3) begin
      do_event(4'b0100, 4'b0000);
      release_all();
    end
    do_event(4'b0100, 4'b0100);
    checks++; if (sp(2) !== 8'd0) begin errors++; $display("FAIL simfull_spots: got %0d exp 0", sp(2)); end
    checks++; if (reject[2] !== 1'b0) begin errors++; $display("FAIL simfull_reject: got %b exp 0", reject[2]); end
    checks++; if (gate_open[2] !== 1'b1) begin errors++; $display("FAIL simfull_gate: got %b exp 1", gate_open[2]); end
    checks++; if (zone_full[2] !== 1'b1) begin errors++; $display("FAIL simfull_flag: got %b exp 1", zone_full[2]); end
    release_all();
    repeat (3) begin
      do_event(4'b0000, 4'b0100);
      release_all();
    end
    checks++; if (sp(2) !== 8'd3 || zone_empty[2] !== 1'b1) begin
      errors++; $display("FAIL drain2: spots %0d empty %b exp 3 1", sp(2), zone_empty[2]);
    end
    do_event(4'b0100, 4'b0100);
    checks++; if (sp(2) !== 8'd3) begin errors++; $display("FAIL simempty_spots: got %0d exp 3", sp(2)); end
    checks++; if (underflow[2] !== 1'b0) begin errors++; $display("FAIL simempty_unf: got %b exp 0", underflow[2]); end
    checks++; if (gate_open[2] !== 1'b1) begin errors++; $display("FAIL simempty_gate: got %b exp 1", gate_open[2]); end
    release_all();
  endtask

  task automatic test_underflow();
    do_event(4'b0000, 4'b1000);
    checks++; if (underflow !== 4'b1000) begin errors++; $display("FAIL unf_set: got %b exp 1000", underflow); end
    checks++; if (sp(3) !== 8'd3) begin errors++; $display("FAIL unf_spots: got %0d exp 3", sp(3)); end
    release_all();
    do_event(4'b1000, 4'b0000);
    checks++; if (sp(3) !== 8'd2) begin errors++; $display("FAIL unf_entry_spots: got %0d exp 2", sp(3)); end
    checks++; if (underflow[3] !== 1'b1) begin errors++; $display("FAIL unf_sticky: got %b exp 1", underflow[3]); end
    release_all();
  endtask

  task automatic test_gate_timing();
    wait_tick();
    car_enter[0] = 1'b1;
    wait_tick();
    @(negedge clk_in);
    checks++; if (gate_open[0] !== 1'b1) begin errors++; $display("FAIL gate_t0: got %b exp 1", gate_open[0]); end
    car_enter[0] = 1'b0;
    wait_tick();
    car_enter[0] = 1'b1;
    @(negedge clk_in);
    checks++; if (gate_open[0] !== 1'b1) begin errors++; $display("FAIL gate_t1: got %b exp 1", gate_open[0]); end
    wait_tick();
    @(negedge clk_in);
    checks++; if (gate_open[0] !== 1'b1) begin errors++; $display("FAIL gate_extend_t2: got %b exp 1", gate_open[0]); end
    car_enter[0] = 1'b0;
    wait_tick();
    @(negedge clk_in);
    checks++; if (gate_open[0] !== 1'b1) begin errors++; $display("FAIL gate_extend_t3: got %b exp 1", gate_open[0]); end
    wait_tick();
    @(negedge clk_in);
    checks++; if (gate_open[0] !== 1'b0) begin errors++; $display("FAIL gate_close_t4: got %b exp 0", gate_open[0]); end
    checks++; if (sp(0) !== 8'd1) begin errors++; $display("FAIL gate_spots: got %0d exp 1", sp(0)); end
    wait_tick();
  endtask

  task automatic test_glitch();
    wait_tick();
    repeat (3) @(negedge clk_in);
    car_enter[3] = 1'b1;
    repeat (2) @(negedge clk_in);
    car_enter[3] = 1'b0;
    wait_tick();
    wait_tick();
    @(negedge clk_in);
    checks++; if (sp(3) !== 8'd2) begin errors++; $display("FAIL glitch_spots: got %0d exp 2", sp(3)); end
    checks++; if (total_free !== TW'(6)) begin errors++; $display("FAIL glitch_total: got %0d exp 6", total_free); end
    checks++; if (underflow !== 4'b1000) begin errors++; $display("FAIL glitch_unf: got %b exp 1000", underflow); end
  endtask

  task automatic test_reset_midrun();
    do_event(4'b0000, 4'b0010);
    checks++; if (sp(1) !== 8'd1 || zone_full[1] !== 1'b0) begin
      errors++; $display("FAIL occ2_spots: spots %0d full %b exp 1 0", sp(1), zone_full[1]);
    end
    car_exit = '0;
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    check_reset_values("midrst");
    reset = 1'b1;
    wait_tick();
    wait_tick();
    checks++; if (spots !== {4{8'd3}} || underflow !== 4'b0000) begin
      errors++; $display("FAIL post_reset: spots %h unf %b exp 03030303 0000", spots, underflow);
    end
  endtask

  initial begin
    test_reset();
    test_fill_reject();
    test_simultaneous();
    test_underflow();
    test_gate_timing();
    test_glitch();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/parking_zone_ctrl.md
# parking_zone_ctrl

Multi-zone parking occupancy controller, the parametrised successor to the single-lot spot counter. It tracks ZONES independent zones, each with a configurable capacity, and drives per-zone free-spot counts, full/empty flags, an aggregate free count, and a timed entry-gate FSM per zone. Entry and exit sensors are synchronised, edge-detected and sampled on an internal prescaler tick, so no divided clock is generated. It sits between the lot sensor front-end and the display/gate actuators.

## Interface
- ZONES, 4: number of zones (≥2).
- CAP_W, 8: width of per-zone counters.
- CAPACITY, 15: spots per zone, 1 ≤ CAPACITY ≤ 2^CAP_W−1.
- DIV_VAL, 200000: clk_in cycles per tick, ≥1.
- GATE_TICKS, 4: ticks the gate stays open after an accepted entry, ≥1.
- TOT_W, CAP_W+$clog2(ZONES): derived width of total_free.

Ports (name, direction, width, meaning):
- clk_in  in  1  single system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-low reset.
- car_enter  in  ZONES  per-zone entry sensor levels, asynchronous.
- car_exit  in  ZONES  per-zone exit sensor levels, asynchronous.
- spots  out  ZONES*CAP_W  packed free count; zone z occupies bits [z*CAP_W +: CAP_W].
- zone_full  out  ZONES  1 when the zone's occupancy equals CAPACITY.
- zone_empty  out  ZONES  1 when the zone's occupancy is 0.
- total_free  out  TOT_W  sum of all zone free counts.
- gate_open  out  ZONES  1 while the zone's gate FSM is in OPEN.
- reject  out  ZONES  one-cycle pulse: entry event refused because the zone is full.
- underflow  out  ZONES  sticky flag: exit event seen while the zone was empty.
- tick_out  out  1  prescaler tick, one clk_in cycle wide.

## Operation
- Prescaler: counter runs 0..DIV_VAL−1 and wraps; tick is high in the cycle where the counter equals DIV_VAL−1. With DIV_VAL=1, tick is high every cycle.
- Each sensor bit goes through a 2-flop synchroniser.
- On tick, each synchronised bit is compared with its last tick-sampled value. An event is sampled high while the previous sample was low. The previous-sample register then updates.
- Pulses shorter than one tick period may be missed. That is accepted behaviour.
- Per-zone occupancy occ, updated only on tick:
  - enter only, occ<CAPACITY: occ+1, entry accepted.
  - enter only, occ==CAPACITY: occ unchanged, reject pulses.
  - exit only, occ>0: occ−1.
  - exit only, occ==0: occ unchanged, underflow set.
  - enter and exit together: occ unchanged, entry accepted, no reject, no underflow. This holds at full and at empty.
- spots = CAPACITY−occ. zone_full, zone_empty and total_free are registered, derived from next-state occ, and consistent with spots in the same cycle.
- Gate FSM per zone:
  - States: CLOSED, OPEN.
  - CLOSED→OPEN on an accepted entry; the timer loads GATE_TICKS.
  - In OPEN the timer decrements on each tick; OPEN→CLOSED on the tick where the timer reaches 0.
  - An accepted entry while OPEN reloads the timer to GATE_TICKS and stays in OPEN.
  - A rejected entry never opens the gate.
- underflow clears only on reset.

## Timing
- Reset (reset=0 at a clk_in edge) sets:
  - prescaler = 0, synchronisers = 0, previous-sample registers = 1 (a sensor held high through reset creates no event);
  - occ = 0, spots = CAPACITY, zone_empty = all 1s, zone_full = 0;
  - total_free = ZONES*CAPACITY;
  - gate_open = 0, FSM = CLOSED, reject = 0, underflow = 0, tick_out = 0.
- Reset asserted mid-operation takes effect at the next edge and overrides all pending events. The first tick after release occurs DIV_VAL cycles after release.
- Latency from a sensor edge to the output update:
  - the sensor edge needs 2 cycles to reach the synchronised value;
  - the event is taken at the next tick edge;
  - spots, flags, total_free, reject and gate_open change on the same edge that samples the tick.
  - Worst case is 2+DIV_VAL cycles.
- reject is high for exactly one clk_in cycle per refused event.
- gate_open stays high for GATE_TICKS ticks after the last accepted entry.

## Test plan
Use DIV_VAL=4, CAPACITY=3, ZONES=4, GATE_TICKS=2.
- Reset, then release: spots = 3 per zone, total_free = 12, zone_empty = 4'b1111. Hold car_enter[0] high through reset and release: no event, spots[0] stays 3.
- Four separate entries on zone 1: spots[1] goes 2, 1, 0; zone_full[1] = 1 after the third; the fourth gives a one-cycle reject[1] and gate_open[1] stays in its prior state; total_free = 9.
- Zone 2 full, car_enter[2] and car_exit[2] rise together: spots[2] stays 0, no reject, gate opens. Repeat at empty: spots stays 3, underflow stays 0.
- car_exit[3] rises with zone 3 empty: underflow[3] = 1 and stays 1 after later entries, until reset.
- Gate timing: an entry on zone 0 opens the gate for 2 ticks (8 cycles). A second entry after 1 tick extends the open period to 2 ticks from that event.
- Glitch: a car_enter pulse 2 cycles wide placed between ticks gives no count change. Assert reset mid-count with zone 1 at occ = 2: all outputs return to reset values at the next edge.
